div_seq: RTL and testbench



---
 rtl/div_seq_if.sv | 24 ++
 rtl/div_seq.sv | 118 +++++++++++
 tb/tb_div_seq.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Request/response bundle for div_seq: operands with valid/ready, a flush strobe,
// and the held result with its own valid/ready plus a busy indication.
interface div_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op, dividend, divisor, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, dividend, divisor, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider (DIV/DIVU/REM/REMU): out_valid WIDTH+1 edges after accept, 1 edge for /0 and overflow.
// Result held in DONE until out_ready; in_ready only in IDLE; flush or reset abandon any operation.
module div_seq #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  div_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]       op_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic             special_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             is_signed;
  logic             dvd_neg;
  logic             dsr_neg;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign accept    = bus.in_valid & (state == IDLE) & ~bus.flush;
  assign is_signed = ~bus.op[0];
  assign dvd_neg   = is_signed & bus.dividend[WIDTH-1];
  assign dsr_neg   = is_signed & bus.divisor[WIDTH-1];
  assign dvd_mag   = dvd_neg ? -bus.dividend : bus.dividend;
  assign dsr_mag   = dsr_neg ? -bus.divisor : bus.divisor;
  assign div_zero  = (bus.divisor == '0);
  assign overflow  = is_signed & (bus.dividend == MIN_NEG) & (bus.divisor == '1);

  // Partial remainder can exceed 2^(WIDTH-1), so the shifted value keeps its carry bit.
  assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, dsr_q};
  assign q_bit    = ~rem_diff[WIDTH];

  assign quo_fix = quo_neg_q ? -quo_q : quo_q;
  assign rem_fix = rem_neg_q ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Special cases pass through FIX with the preloaded result so they surface one edge after accept.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid) state_nxt = (div_zero | overflow) ? FIX : ITER;
        ITER:    if (cnt_q == '0) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      special_q <= 1'b0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      op_q      <= bus.op;
      quo_neg_q <= dvd_neg ^ dsr_neg;
      rem_neg_q <= dvd_neg;
      special_q <= div_zero | overflow;
      dvd_q     <= dvd_mag;
      dsr_q     <= dsr_mag;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= CW'(WIDTH - 1);
      if (div_zero)      result_q <= bus.op[1] ? bus.dividend : '1;
      else if (overflow) result_q <= bus.op[1] ? '0 : bus.dividend;
    end else if (!bus.flush && state == ITER) begin
      dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
      rem_q <= q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], q_bit};
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end else if (!bus.flush && state == FIX && !special_q) begin
      result_q <= op_q[1] ? rem_fix : quo_fix;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed, special-case, random, backpressure, flush and reset scenarios
// on a 32-bit and an 8-bit instance, checked against an arithmetic reference model.
module tb_div_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec = 0;
  int   miscmp = 0;

  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(32)) b32 ();
  div_seq_if #(.WIDTH(8))  b8 ();

  div_seq #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32));
  div_seq #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8));

  // Reference: plain signed/unsigned arithmetic on width-w values plus the RISC-V corner rules.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    logic [63:0] mask, half, ua, ub, qu, ru;
    longint sa, sb, qs, rs;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = $signed(ua ^ half) - $signed(half);
    sb = $signed(ub ^ half) - $signed(half);
    if (ub == 64'd0) begin
      qu = mask;
      ru = ua;
    end else if (!op[0]) begin
      if (sa == -$signed(half) && sb == -64'sd1) begin
        qs = sa;
        rs = 0;
      end else begin
        qs = sa / sb;
        rs = sa % sb;
      end
      qu = qs;
      ru = rs;
    end else begin
      qu = ua / ub;
      ru = ua % ub;
    end
    model = 32'((op[1] ? ru : qu) & mask);
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int w);
    logic [63:0] mask, ua, ub;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    if (ub == 64'd0) return 1;
    if (!op[0] && ua == (64'd1 << (w - 1)) && ub == mask) return 1;
    return w + 1;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] v;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 6))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'(64'd1 << (w - 1));
      3:       v = 32'($urandom_range(1, 9));
      4:       v = 32'(-$urandom_range(1, 9));
      default: v = $urandom();
    endcase
    return v & 32'(mask);
  endfunction

  function automatic logic rdy(input bit n);
    return n ? b8.in_ready : b32.in_ready;
  endfunction

  function automatic logic ov(input bit n);
    return n ? b8.out_valid : b32.out_valid;
  endfunction

  function automatic logic [31:0] res(input bit n);
    return n ? {24'd0, b8.result} : b32.result;
  endfunction

  task automatic drive(input bit n, input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (n) begin
      b8.in_valid = v;  b8.op = op;  b8.dividend = a[7:0];  b8.divisor = b[7:0];
    end else begin
      b32.in_valid = v; b32.op = op; b32.dividend = a;      b32.divisor = b;
    end
  endtask

  task automatic set_out_ready(input bit n, input logic v);
    if (n) b8.out_ready = v;
    else   b32.out_ready = v;
  endtask

  // Waits for in_ready, presents one request for a single edge, then scrambles the operands.
  task automatic issue(input bit n, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!rdy(n) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!rdy(n)) begin
      vec++; miscmp++;
      $display("FAIL issue_wait: in_ready=0 after %0d cycles, required 1", k);
    end
    drive(n, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(n, 1'b0, 2'($urandom()), $urandom(), $urandom());
  endtask

  task automatic collect(input bit n, output logic [31:0] r, output int lat);
    lat = 0;
    while (!ov(n) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res(n);
  endtask

  task automatic take(input bit n);
    set_out_ready(n, 1'b1);
    @(posedge clk); #1;
    set_out_ready(n, 1'b0);
  endtask

  task automatic test_reset;
    b32.in_valid = 0; b32.op = 0; b32.dividend = 0; b32.divisor = 0; b32.flush = 0; b32.out_ready = 0;
    b8.in_valid = 0;  b8.op = 0;  b8.dividend = 0;  b8.divisor = 0;  b8.flush = 0;  b8.out_ready = 0;
    #12;
    vec++; if (b32.in_ready !== 1'b1) begin miscmp++; $display("FAIL reset_in_ready got %b want 1", b32.in_ready); end
    vec++; if (b32.out_valid !== 1'b0) begin miscmp++; $display("FAIL reset_out_valid got %b want 0", b32.out_valid); end
    vec++; if (b32.busy !== 1'b0) begin miscmp++; $display("FAIL reset_busy got %b want 0", b32.busy); end
    vec++; if (b32.result !== 32'd0) begin miscmp++; $display("FAIL reset_result got %h want 0", b32.result); end
    vec++; if (b8.in_ready !== 1'b1 || b8.result !== 8'd0) begin
      miscmp++; $display("FAIL reset_w8 got rdy=%b res=%h want 1/00", b8.in_ready, b8.result);
    end
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [1:0]  d_op [6];
    logic [31:0] d_a [6], d_b [6], d_exp [6];
    logic [31:0] r;
    int lat;
    d_op  = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1};
    d_a   = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF};
    d_b   = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd1};
    d_exp = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      issue(0, d_op[i], d_a[i], d_b[i]);
      collect(0, r, lat);
      vec++; if (r !== d_exp[i]) begin miscmp++; $display("FAIL directed[%0d] result got %h want %h", i, r, d_exp[i]); end
      vec++; if (lat != 33) begin miscmp++; $display("FAIL directed[%0d] latency got %0d want 33", i, lat); end
      take(0);
    end
  endtask

  task automatic test_special;
    logic [1:0]  s_op [4];
    logic [31:0] s_a [4], s_b [4], s_exp [4];
    logic [31:0] r;
    int lat;
    s_op  = '{2'd0, 2'd3, 2'd0, 2'd2};
    s_a   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    s_b   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    s_exp = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      issue(0, s_op[i], s_a[i], s_b[i]);
      collect(0, r, lat);
      vec++; if (r !== s_exp[i]) begin miscmp++; $display("FAIL special[%0d] result got %h want %h", i, r, s_exp[i]); end
      vec++; if (lat != 1) begin miscmp++; $display("FAIL special[%0d] latency got %0d want 1", i, lat); end
      take(0);
    end
  endtask

  task automatic test_random(input bit n, input int count);
    logic [1:0]  op;
    logic [31:0] a, b, r, exp;
    int lat, w;
    w = n ? 8 : 32;
    for (int i = 0; i < count; i++) begin
      op = 2'($urandom());
      a = pick(w);
      b = pick(w);
      exp = model(op, a, b, w);
      issue(n, op, a, b);
      collect(n, r, lat);
      vec++; if (r !== exp) begin
        miscmp++; $display("FAIL random_w%0d op=%0d a=%h b=%h got %h want %h", w, op, a, b, r, exp);
      end
      vec++; if (lat != model_lat(op, a, b, w)) begin
        miscmp++; $display("FAIL random_w%0d_lat op=%0d a=%h b=%h got %0d want %0d", w, op, a, b, lat, model_lat(op, a, b, w));
      end
      take(n);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a, b, r, exp;
    int lat, bad;
    a = $urandom();
    b = 32'($urandom_range(1, 1000));
    exp = model(2'd1, a, b, 32);
    issue(0, 2'd1, a, b);
    collect(0, r, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (b32.result !== exp || b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0) bad++;
    end
    vec++; if (bad != 0) begin
      miscmp++; $display("FAIL backpressure_hold got %0d unstable cycles want 0 (res=%h want %h)", bad, b32.result, exp);
    end
    take(0);
    vec++; if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
      miscmp++; $display("FAIL backpressure_release got rdy=%b vld=%b want 1/0", b32.in_ready, b32.out_valid);
    end
    issue(0, 2'd3, 32'd100, 32'd7);
    collect(0, r, lat);
    vec++; if (r !== 32'd2 || lat != 33) begin
      miscmp++; $display("FAIL backpressure_next got %h lat %0d want 00000002 lat 33", r, lat);
    end
    take(0);
  endtask

  task automatic test_flush;
    logic [31:0] r;
    int lat, seen;
    issue(0, 2'd1, 32'd1000, 32'd3);
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    b32.flush = 1; b32.in_valid = 1; b32.out_ready = 1;
    @(posedge clk); #1;
    b32.flush = 0; b32.in_valid = 0; b32.out_ready = 0;
    vec++; if (b32.in_ready !== 1'b1 || b32.busy !== 1'b0 || b32.out_valid !== 1'b0) begin
      miscmp++; $display("FAIL flush_idle got rdy=%b busy=%b vld=%b want 1/0/0", b32.in_ready, b32.busy, b32.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (b32.out_valid) seen++; end
    vec++; if (seen != 0) begin miscmp++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
    b32.flush = 1; b32.in_valid = 1; b32.op = 2'd1; b32.dividend = 32'd9; b32.divisor = 32'd3;
    @(posedge clk); #1;
    b32.flush = 0; b32.in_valid = 0;
    vec++; if (b32.busy !== 1'b0) begin miscmp++; $display("FAIL flush_overrides_accept got busy=%b want 0", b32.busy); end
    issue(0, 2'd1, 32'd9, 32'd3);
    collect(0, r, lat);
    vec++; if (r !== 32'd3 || lat != 33) begin
      miscmp++; $display("FAIL flush_next got %h lat %0d want 00000003 lat 33", r, lat);
    end
    take(0);
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int lat, seen;
    issue(0, 2'd1, 32'hDEAD_BEEF, 32'd17);
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
    #2 reset = 1;
    #1;
    vec++; if (b32.in_ready !== 1'b1 || b32.busy !== 1'b0 || b32.out_valid !== 1'b0) begin
      miscmp++; $display("FAIL async_reset got rdy=%b busy=%b vld=%b want 1/0/0", b32.in_ready, b32.busy, b32.out_valid);
    end
    vec++; if (b32.result !== 32'd0) begin miscmp++; $display("FAIL async_reset_result got %h want 0", b32.result); end
    @(negedge clk); reset = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (b32.out_valid) seen++; end
    vec++; if (seen != 0) begin miscmp++; $display("FAIL reset_no_result got %0d valid cycles want 0", seen); end
    issue(0, 2'd1, 32'd9, 32'd3);
    collect(0, r, lat);
    vec++; if (r !== 32'd3) begin miscmp++; $display("FAIL reset_next got %h want 00000003", r); end
    take(0);
  endtask

  task automatic test_width8;
    logic [31:0] r;
    int lat;
    issue(1, 2'd0, 32'h80, 32'h03);
    collect(1, r, lat);
    vec++; if (r !== 32'hD6) begin miscmp++; $display("FAIL w8_div got %h want d6", r); end
    vec++; if (lat != 9) begin miscmp++; $display("FAIL w8_div_lat got %0d want 9", lat); end
    take(1);
    issue(1, 2'd2, 32'h80, 32'h03);
    collect(1, r, lat);
    vec++; if (r !== 32'hFE) begin miscmp++; $display("FAIL w8_rem got %h want fe", r); end
    vec++; if (lat != 9) begin miscmp++; $display("FAIL w8_rem_lat got %0d want 9", lat); end
    take(1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_random(0, 40);
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_width8();
    test_random(1, 40);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
